carfield_regbus_decode_responder: RTL

// - Responder side of the peripheral address map: takes single-outstanding register requests

---
 rtl/carfield_regbus_decode_responder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/carfield_regbus_decode_responder.sv
// Register-bus responder: decodes single-outstanding requests onto NumMst windows.
// Optional timeout path: define CARFIELD_REGBUS_DECODE_TIMEOUT_EN.
module carfield_regbus_decode_responder #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumMst = 4,
  parameter logic [NumMst*AddrWidth-1:0] MstBase = {
    48'h0000_200B_0000, 48'h0000_200A_0000,
    48'h0000_2002_0000, 48'h0000_2001_0000
  },
  parameter logic [NumMst*AddrWidth-1:0] MstSize = {4{48'h1000}},
  parameter logic [NumMst-1:0] MstEnable = {NumMst{1'b1}},
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        slv_req_valid_i,
  output logic                        slv_req_ready_o,
  input  logic [AddrWidth-1:0]        slv_addr_i,
  input  logic                        slv_write_i,
  input  logic [DataWidth-1:0]        slv_wdata_i,
  input  logic [DataWidth/8-1:0]      slv_wstrb_i,
  output logic                        slv_rsp_valid_o,
  input  logic                        slv_rsp_ready_i,
  output logic [DataWidth-1:0]        slv_rdata_o,
  output logic                        slv_error_o,
  output logic [NumMst-1:0]           mst_req_valid_o,
  input  logic [NumMst-1:0]           mst_req_ready_i,
  output logic [AddrWidth-1:0]        mst_addr_o,
  output logic                        mst_write_o,
  output logic [DataWidth-1:0]        mst_wdata_o,
  output logic [DataWidth/8-1:0]      mst_wstrb_o,
  input  logic [NumMst-1:0]           mst_rsp_valid_i,
  input  logic [NumMst*DataWidth-1:0] mst_rdata_i,
  input  logic [NumMst-1:0]           mst_error_i
);

  localparam int unsigned IdxW =
    (NumMst > 1) ? $clog2(NumMst) : 1;
  localparam logic [DataWidth-1:0] MissData =
    DataWidth'(32'hBADC_AB1E);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    WAIT_RSP,
    RESP
  } state_e;

  state_e          state;
  logic [IdxW-1:0] idx;

  logic [NumMst-1:0] hit;
  logic              dec_hit;
  logic [IdxW-1:0]   dec_idx;
  logic [NumMst-1:0] dec_onehot;
  logic [AddrWidth:0] a_ext;
  logic [AddrWidth:0] lo;
  logic [AddrWidth:0] hi;

  logic                 sel_ready;
  logic                 sel_rsp;
  logic [DataWidth-1:0] sel_rdata;
  logic                 sel_err;

  if (TimeoutCycles < 1) begin : g_bad_cfg
    $error("TimeoutCycles must be >= 1");
  end

`ifdef CARFIELD_REGBUS_DECODE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [DataWidth-1:0] TmoData =
    DataWidth'(32'hDEAD_BEEF);
  logic [CntW-1:0] cnt;
  logic            tmo;
  assign tmo = (cnt == CntW'(TimeoutCycles - 1));
`endif

  // Window decode; the extra MSB keeps base+size from wrapping.
  always_comb begin
    hit        = '0;
    dec_hit    = 1'b0;
    dec_idx    = '0;
    dec_onehot = '0;
    a_ext      = {1'b0, slv_addr_i};
    lo         = '0;
    hi         = '0;
    for (int i = 0; i < int'(NumMst); i++) begin
      lo = {1'b0, MstBase[i*AddrWidth +: AddrWidth]};
      hi = lo + {1'b0, MstSize[i*AddrWidth +: AddrWidth]};
      hit[i] = MstEnable[i] && (a_ext >= lo) && (a_ext < hi);
      if (hit[i] && !dec_hit) begin
        dec_hit       = 1'b1;
        dec_idx       = IdxW'(i);
        dec_onehot[i] = 1'b1;
      end
    end
  end

  // Mux the handshake and response of the latched port.
  always_comb begin
    sel_ready = 1'b0;
    sel_rsp   = 1'b0;
    sel_rdata = '0;
    sel_err   = 1'b0;
    for (int i = 0; i < int'(NumMst); i++) begin
      if (idx == IdxW'(i)) begin
        sel_ready = mst_req_ready_i[i];
        sel_rsp   = mst_rsp_valid_i[i];
        sel_rdata = mst_rdata_i[i*DataWidth +: DataWidth];
        sel_err   = mst_error_i[i];
      end
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      idx             <= '0;
      slv_req_ready_o <= 1'b1;
      slv_rsp_valid_o <= 1'b0;
      slv_rdata_o     <= '0;
      slv_error_o     <= 1'b0;
      mst_req_valid_o <= '0;
      mst_addr_o      <= '0;
      mst_write_o     <= 1'b0;
      mst_wdata_o     <= '0;
      mst_wstrb_o     <= '0;
`ifdef CARFIELD_REGBUS_DECODE_TIMEOUT_EN
      cnt             <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (slv_req_valid_i) begin
            slv_req_ready_o <= 1'b0;
            mst_addr_o      <= slv_addr_i;
            mst_write_o     <= slv_write_i;
            mst_wdata_o     <= slv_wdata_i;
            mst_wstrb_o     <= slv_wstrb_i;
            idx             <= dec_idx;
`ifdef CARFIELD_REGBUS_DECODE_TIMEOUT_EN
            cnt             <= '0;
`endif
            if (dec_hit) begin
              state           <= FWD;
              mst_req_valid_o <= dec_onehot;
            end else begin
              state           <= RESP;
              slv_rsp_valid_o <= 1'b1;
              slv_error_o     <= 1'b1;
              slv_rdata_o     <= MissData;
            end
          end
        end
        FWD: begin
`ifdef CARFIELD_REGBUS_DECODE_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
          if (sel_ready) begin
            mst_req_valid_o <= '0;
            if (sel_rsp) begin
              state           <= RESP;
              slv_rsp_valid_o <= 1'b1;
              slv_error_o     <= sel_err;
              slv_rdata_o     <= mst_write_o ? '0 : sel_rdata;
            end else begin
              state <= WAIT_RSP;
            end
          end
`ifdef CARFIELD_REGBUS_DECODE_TIMEOUT_EN
          else if (tmo) begin
            mst_req_valid_o <= '0;
            state           <= RESP;
            slv_rsp_valid_o <= 1'b1;
            slv_error_o     <= 1'b1;
            slv_rdata_o     <= TmoData;
          end
`endif
        end
        WAIT_RSP: begin
`ifdef CARFIELD_REGBUS_DECODE_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
          if (sel_rsp) begin
            state           <= RESP;
            slv_rsp_valid_o <= 1'b1;
            slv_error_o     <= sel_err;
            slv_rdata_o     <= mst_write_o ? '0 : sel_rdata;
          end
`ifdef CARFIELD_REGBUS_DECODE_TIMEOUT_EN
          else if (tmo) begin
            state           <= RESP;
            slv_rsp_valid_o <= 1'b1;
            slv_error_o     <= 1'b1;
            slv_rdata_o     <= TmoData;
          end
`endif
        end
        RESP: begin
          if (slv_rsp_ready_i) begin
            state           <= IDLE;
            slv_rsp_valid_o <= 1'b0;
            slv_rdata_o     <= '0;
            slv_error_o     <= 1'b0;
            slv_req_ready_o <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
